// File: rtl/reg_file.sv
// 32x32 integer register file with two combinational read ports, optional
// writeback forwarding, and a busy scoreboard that generates decode stalls.
module reg_file #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        rs1_used_i,
  input  logic        rs2_used_i,
  output logic [31:0] reg1_data_o,
  output logic [31:0] reg2_data_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic        stall_o,
  output logic [31:0] busy_o
);

  logic [31:0] mem_reg [32];
  logic [31:0] busy_reg;
  logic [31:0] busy_next;
  logic        wr_live;
  logic        fwd1;
  logic        fwd2;
  logic        pend1;
  logic        pend2;
  logic        issue_go;

  assign wr_live = wr_en_i && (wr_addr_i != 5'd0);

  // Entry 0 is held at zero so x0 never needs special handling on the write side.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_mem
      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          mem_reg[gi] <= '0;
        end else if ((gi != 0) && wr_live && (wr_addr_i == 5'(gi))) begin
          mem_reg[gi] <= wr_data_i;
        end
      end
    end
  endgenerate

  assign fwd1 = BYPASS_EN && wr_live && (wr_addr_i == rs1_addr_i);
  assign fwd2 = BYPASS_EN && wr_live && (wr_addr_i == rs2_addr_i);

  // While reset is held the array still has stale contents, so mask it.
  always_comb begin
    reg1_data_o = '0;
    reg2_data_o = '0;
    if (fwd1) begin
      reg1_data_o = wr_data_i;
    end else if (rst_n_i && (rs1_addr_i != 5'd0)) begin
      reg1_data_o = mem_reg[rs1_addr_i];
    end
    if (fwd2) begin
      reg2_data_o = wr_data_i;
    end else if (rst_n_i && (rs2_addr_i != 5'd0)) begin
      reg2_data_o = mem_reg[rs2_addr_i];
    end
  end

  assign pend1 = rst_n_i && rs1_used_i && (rs1_addr_i != 5'd0) &&
                 busy_reg[rs1_addr_i] && !fwd1;
  assign pend2 = rst_n_i && rs2_used_i && (rs2_addr_i != 5'd0) &&
                 busy_reg[rs2_addr_i] && !fwd2;
  assign stall_o = pend1 || pend2;

  assign issue_go = issue_i && !stall_o && (issue_rd_i != 5'd0);

  // Clear before set: a newer producer issued this cycle keeps the bit pending.
  always_comb begin
    busy_next = busy_reg;
    if (wr_live) begin
      busy_next[wr_addr_i] = 1'b0;
    end
    if (issue_go) begin
      busy_next[issue_rd_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_o = busy_reg;

endmodule

// File: tb/tb_reg_file.sv
// Directed scoreboard bench for reg_file: forwarding instance and a
// non-forwarding instance share stimulus; a monitor checks at negedge.
module tb_reg_file;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, issue_rd_i, wr_addr_i;
  logic        rs1_used_i, rs2_used_i, issue_i, wr_en_i;
  logic [31:0] wr_data_i;
  logic [31:0] r1_b, r2_b, busy_b, r1_n, r2_n, busy_n;
  logic        stall_b, stall_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit stim_done = 1'b0;

  always #5 clk_i = ~clk_i;

  reg_file #(.BYPASS_EN(1'b1)) dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .reg1_data_o(r1_b), .reg2_data_o(r2_b),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .stall_o(stall_b), .busy_o(busy_b)
  );

  reg_file #(.BYPASS_EN(1'b0)) dut_n (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .reg1_data_o(r1_n), .reg2_data_o(r2_n),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .stall_o(stall_n), .busy_o(busy_n)
  );

  typedef struct {
    string       name;
    logic [31:0] r1, r2, busy;
    logic        stall;
    logic [31:0] r1_nb, r2_nb;
    logic        stall_nb;
    bit          chk_busy;
  } exp_t;

  exp_t exp_q[$];

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                       input logic u1, input logic u2,
                       input logic iss, input logic [4:0] ird,
                       input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rn);
    @(posedge clk_i);
    #1;
    rs1_addr_i = a1; rs2_addr_i = a2; rs1_used_i = u1; rs2_used_i = u2;
    issue_i = iss; issue_rd_i = ird;
    wr_en_i = we; wr_addr_i = wa; wr_data_i = wd; rst_n_i = rn;
  endtask

  // Full expectation including the non-forwarding instance.
  task automatic expect2(input string nm, input logic [31:0] r1, input logic [31:0] r2,
                         input logic st, input logic [31:0] bz, input bit cb,
                         input logic [31:0] r1n, input logic [31:0] r2n, input logic stn);
    exp_t e;
    e.name = nm; e.r1 = r1; e.r2 = r2; e.stall = st; e.busy = bz; e.chk_busy = cb;
    e.r1_nb = r1n; e.r2_nb = r2n; e.stall_nb = stn;
    exp_q.push_back(e);
  endtask

  // Both instances expected to agree.
  task automatic expect1(input string nm, input logic [31:0] r1, input logic [31:0] r2,
                         input logic st, input logic [31:0] bz, input bit cb);
    expect2(nm, r1, r2, st, bz, cb, r1, r2, st);
  endtask

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endfunction

  // Monitor: combinational outputs are settled mid-cycle, so sample on negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp({e.name, ".reg1"},     r1_b, e.r1);
        cmp({e.name, ".reg2"},     r2_b, e.r2);
        cmp({e.name, ".stall"},    32'(stall_b), 32'(e.stall));
        cmp({e.name, ".nb.reg1"},  r1_n, e.r1_nb);
        cmp({e.name, ".nb.reg2"},  r2_n, e.r2_nb);
        cmp({e.name, ".nb.stall"}, 32'(stall_n), 32'(e.stall_nb));
        if (e.chk_busy) begin
          cmp({e.name, ".busy"},    busy_b, e.busy);
          cmp({e.name, ".nb.busy"}, busy_n, e.busy);
        end
        $display("txn %-16s r1=%h r2=%h stall=%0b busy=%h", e.name, r1_b, r2_b, stall_b, busy_b);
      end
    end
  end

  initial begin
    rst_n_i = 1'b0; rs1_addr_i = '0; rs2_addr_i = '0; rs1_used_i = 1'b0; rs2_used_i = 1'b0;
    issue_i = 1'b0; issue_rd_i = '0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;

    // Reset: reads masked and no stall even before state is known.
    drive(5'd3, 5'd7, 1, 1, 0, 0, 0, 0, 0, 0);
    expect1("rst0", 0, 0, 0, 0, 0);
    drive(5'd3, 5'd7, 1, 1, 0, 0, 0, 0, 0, 0);
    expect1("rst1", 0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 1, 1, 0, 0, 0, 0, 0, 1);
      expect1($sformatf("rd_all%0d", i), 0, 0, 0, 0, 1);
    end

    // Write x5: forwarded same cycle only with bypass, visible to both next cycle.
    drive(5'd5, 5'd0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 1);
    expect2("wr_x5", 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0);
    drive(5'd5, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect1("rd_x5", 32'hDEADBEEF, 0, 0, 0, 1);
    drive(5'd0, 5'd5, 0, 0, 0, 0, 1, 5'd0, 32'h1234, 1);
    expect1("wr_x0", 0, 32'hDEADBEEF, 0, 0, 1);
    drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect1("rd_x0", 0, 0, 0, 0, 1);

    // Issue rd=7, consumer waits, writeback releases it.
    drive(5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 0, 0, 1);
    expect1("iss7", 0, 0, 0, 0, 1);
    drive(5'd0, 5'd7, 0, 1, 0, 0, 0, 0, 0, 1);
    expect1("wait7a", 0, 0, 1, 32'h80, 1);
    drive(5'd0, 5'd7, 0, 1, 0, 0, 0, 0, 0, 1);
    expect1("wait7b", 0, 0, 1, 32'h80, 1);
    drive(5'd0, 5'd7, 0, 1, 0, 0, 1, 5'd7, 32'h55, 1);
    expect2("wb7", 0, 32'h55, 0, 32'h80, 1, 0, 0, 1);
    drive(5'd0, 5'd7, 0, 1, 0, 0, 0, 0, 0, 1);
    expect1("after7", 0, 32'h55, 0, 0, 1);

    // Same-cycle set and clear of x3: set wins; unused operand never stalls.
    drive(5'd3, 5'd0, 0, 0, 1, 5'd3, 1, 5'd3, 32'hAA, 1);
    expect2("set_clr3", 32'hAA, 0, 0, 0, 1, 0, 0, 0);
    drive(5'd3, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect1("busy3", 32'hAA, 0, 0, 32'h8, 1);

    // Issue while stalled is dropped.
    drive(5'd3, 5'd0, 1, 0, 1, 5'd9, 0, 0, 0, 1);
    expect1("iss9_stall", 32'hAA, 0, 1, 32'h8, 1);
    drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect1("no_busy9", 0, 0, 0, 32'h8, 1);
    drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd3, 32'h11, 1);
    expect1("clr3", 0, 0, 0, 32'h8, 1);

    // Write x4 (not busy), then mark it busy and stall on it.
    drive(5'd0, 5'd0, 0, 0, 0, 0, 1, 5'd4, 32'h44, 1);
    expect1("wr_x4", 0, 0, 0, 0, 1);
    drive(5'd0, 5'd0, 0, 0, 1, 5'd4, 0, 0, 0, 1);
    expect1("iss4", 0, 0, 0, 0, 1);
    drive(5'd4, 5'd0, 1, 0, 0, 0, 0, 0, 0, 1);
    expect1("stall4", 32'h44, 0, 1, 32'h10, 1);

    // Reset mid-stall; the writeback to x6 in the reset cycle is discarded.
    drive(5'd4, 5'd0, 1, 0, 1, 5'd8, 1, 5'd6, 32'h66, 0);
    expect1("rst_stall", 0, 0, 0, 0, 0);
    drive(5'd4, 5'd6, 1, 1, 0, 0, 0, 0, 0, 1);
    expect1("post_rst", 0, 0, 0, 0, 1);

    drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    #1;
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done || $time > 64'd20000);
    n_checks++;
    if (!stim_done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: done=%0b pending=%0d required done=1 pending=0", stim_done, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
